// File: rtl/acc_exec.sv
// Accumulator execution stage: ALU/compare/jump/register-load in one cycle,
// handshaked data-memory load/store via a two-state FSM. ACC_MEM_TIMEOUT_EN bounds the MEM wait.
module acc_exec #(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   acc_ctl,
    input  logic [5:0]   op,
    input  logic [W-1:0] rs_data,
    input  logic [W-1:0] rt_data,
    input  logic [W-1:0] imm,
    input  logic [W-1:0] mem_rdata,
    input  logic         mem_ack,
    output logic [W-1:0] acc,
    output logic         carry,
    output logic         eq_flag,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         jmp,
    output logic         jr,
    output logic         reg_we,
    output logic [W-1:0] reg_wdata,
    output logic         mem_req,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata
);

    typedef enum logic [0:0] {StIdle, StMem} state_e;

    localparam logic [2:0] CtlErr   = 3'b000;
    localparam logic [2:0] CtlAlu   = 3'b001;
    localparam logic [2:0] CtlShift = 3'b010;
    localparam logic [2:0] CtlEq    = 3'b011;
    localparam logic [2:0] CtlJmp   = 3'b100;
    localparam logic [2:0] CtlStore = 3'b101;
    localparam logic [2:0] CtlLoad  = 3'b110;
    localparam logic [2:0] CtlLdi   = 3'b111;

    state_e state;

    logic [W:0]   add_imm;
    logic [W:0]   add_rs;
    logic [W:0]   sub_rs;
    logic [W-1:0] alu_acc;
    logic         alu_carry;

`ifdef ACC_MEM_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
    logic [CW-1:0] cnt;
    logic          cnt_expired;

    assign cnt_expired = (cnt == CW'(TIMEOUT - 1));
`endif

    assign busy = (state == StMem);

    // The extra top bit carries out of add, and is set on borrow for sub.
    assign add_imm = {1'b0, acc} + {1'b0, imm};
    assign add_rs  = {1'b0, acc} + {1'b0, rs_data};
    assign sub_rs  = {1'b0, acc} - {1'b0, rs_data};

    always_comb begin
        alu_acc   = acc;
        alu_carry = carry;
        case (acc_ctl)
            CtlAlu: begin
                if (op[5:3] == 3'b010) begin
                    {alu_carry, alu_acc} = add_imm;
                end else begin
                    case (op[2:0])
                        3'b000:  {alu_carry, alu_acc} = add_rs;
                        3'b001:  {alu_carry, alu_acc} = sub_rs;
                        3'b010:  alu_acc = acc & rs_data;
                        3'b011:  alu_acc = acc | rs_data;
                        default: ;
                    endcase
                end
            end
            CtlShift: begin
                if (op[5:3] != 3'b110) begin
                    case (op[2:0])
                        3'b101:  alu_acc = {acc[W-2:0], 1'b0};
                        3'b110:  alu_acc = {1'b0, acc[W-1:1]};
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            acc       <= '0;
            carry     <= 1'b0;
            eq_flag   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            jmp       <= 1'b0;
            jr        <= 1'b0;
            reg_we    <= 1'b0;
            reg_wdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef ACC_MEM_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            jmp    <= 1'b0;
            jr     <= 1'b0;
            reg_we <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        case (acc_ctl)
                            CtlAlu: begin
                                acc   <= alu_acc;
                                carry <= alu_carry;
                                done  <= 1'b1;
                            end
                            CtlShift: begin
                                acc  <= alu_acc;
                                jr   <= (op[5:3] == 3'b110);
                                done <= 1'b1;
                            end
                            CtlEq: begin
                                eq_flag <= (rs_data == rt_data);
                                done    <= 1'b1;
                            end
                            CtlJmp: begin
                                jmp  <= 1'b1;
                                done <= 1'b1;
                            end
                            CtlLdi: begin
                                reg_we    <= 1'b1;
                                reg_wdata <= imm;
                                done      <= 1'b1;
                            end
                            CtlStore, CtlLoad: begin
                                mem_addr  <= imm;
                                mem_wdata <= acc;
                                mem_we    <= (acc_ctl == CtlStore);
                                mem_req   <= 1'b1;
                                state     <= StMem;
`ifdef ACC_MEM_TIMEOUT_EN
                                cnt       <= '0;
`endif
                            end
                            CtlErr: begin
                                err  <= 1'b1;
                                done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                StMem: begin
                    if (mem_ack) begin
                        if (!mem_we) begin
                            acc <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        state   <= StIdle;
`ifdef ACC_MEM_TIMEOUT_EN
                    end else if (cnt_expired) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        state   <= StIdle;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_exec.sv
// Directed self-checking bench for acc_exec; timeout steps run only with ACC_MEM_TIMEOUT_EN.
module tb_acc_exec;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   acc_ctl;
    logic [5:0]   op;
    logic [W-1:0] rs_data, rt_data, imm, mem_rdata;
    logic         mem_ack;
    logic [W-1:0] acc, reg_wdata, mem_addr, mem_wdata;
    logic         carry, eq_flag, busy, done, err, jmp, jr, reg_we, mem_req, mem_we;

    int checks = 0;
    int errors = 0;

    acc_exec #(.W(W), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .acc_ctl(acc_ctl), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .acc(acc), .carry(carry), .eq_flag(eq_flag), .busy(busy),
        .done(done), .err(err), .jmp(jmp), .jr(jr), .reg_we(reg_we),
        .reg_wdata(reg_wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] c, input logic [5:0] o, input logic [W-1:0] i);
        start   = 1'b1;
        acc_ctl = c;
        op      = o;
        imm     = i;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; acc_ctl = '0; op = '0;
        rs_data = '0; rt_data = '0; imm = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick();
        tick();
        check("rst_acc", acc, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        tick();

        // addi 0xFF twice, back to back
        issue(3'b001, 6'b010000, 8'hFF);
        tick();
        check("addi1_acc", acc, 8'hFF);
        check("addi1_carry", carry, 0);
        check("addi1_done", done, 1);
        check("addi1_busy", busy, 0);
        tick();
        check("addi2_acc", acc, 8'hFE);
        check("addi2_carry", carry, 1);
        check("addi2_done", done, 1);

        issue(3'b001, 6'b010000, 8'h07);
        tick();
        check("addi3_acc", acc, 8'h05);
        check("addi3_carry", carry, 1);

        // sub with borrow
        issue(3'b001, 6'b000001, 8'h00);
        rs_data = 8'h07;
        tick();
        check("sub_acc", acc, 8'hFE);
        check("sub_carry", carry, 1);

        issue(3'b010, 6'b000101, 8'h00);
        tick();
        check("shl_acc", acc, 8'hFC);
        check("shl_carry_kept", carry, 1);

        issue(3'b001, 6'b000011, 8'h00);
        rs_data = 8'h03;
        tick();
        check("or_acc", acc, 8'hFF);

        issue(3'b001, 6'b000010, 8'h00);
        rs_data = 8'h0F;
        tick();
        check("and_acc", acc, 8'h0F);
        check("and_carry_kept", carry, 1);

        issue(3'b010, 6'b000110, 8'h00);
        tick();
        check("shr_acc", acc, 8'h07);

        issue(3'b010, 6'b110000, 8'h00);
        tick();
        check("jr_pulse", jr, 1);
        check("jr_acc", acc, 8'h07);
        check("jr_done", done, 1);

        issue(3'b100, 6'b000000, 8'h00);
        tick();
        check("jmp_pulse", jmp, 1);
        check("jr_cleared", jr, 0);
        start = 1'b0;
        tick();
        check("jmp_cleared", jmp, 0);
        check("idle_done", done, 0);

        // load with ack in the third MEM cycle; a stray start is ignored
        issue(3'b110, 6'b000000, 8'h20);
        tick();
        check("ld_req", mem_req, 1);
        check("ld_busy", busy, 1);
        check("ld_addr", mem_addr, 8'h20);
        check("ld_we", mem_we, 0);
        check("ld_wdata", mem_wdata, 8'h07);
        check("ld_no_done", done, 0);
        issue(3'b001, 6'b010000, 8'h01);
        tick();
        start = 1'b0;
        check("ld_req2", mem_req, 1);
        check("ld_ignored_start", acc, 8'h07);
        tick();
        check("ld_req3", mem_req, 1);
        check("ld_addr_held", mem_addr, 8'h20);
        mem_ack = 1'b1;
        mem_rdata = 8'h5A;
        tick();
        mem_ack = 1'b0;
        check("ld_acc", acc, 8'h5A);
        check("ld_done", done, 1);
        check("ld_busy_off", busy, 0);
        check("ld_req_off", mem_req, 0);

        // load with ack in the first MEM cycle
        issue(3'b110, 6'b000000, 8'h00);
        tick();
        start = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 8'h33;
        tick();
        mem_ack = 1'b0;
        check("ld_fast_acc", acc, 8'h33);
        check("ld_fast_done", done, 1);

        // store, then async reset mid-MEM
        issue(3'b101, 6'b000000, 8'h10);
        tick();
        start = 1'b0;
        check("st_req", mem_req, 1);
        check("st_we", mem_we, 1);
        check("st_wdata", mem_wdata, 8'h33);
        check("st_addr", mem_addr, 8'h10);
        #2 reset = 1'b1;
        #1;
        check("arst_req", mem_req, 0);
        check("arst_we", mem_we, 0);
        check("arst_acc", acc, 0);
        check("arst_busy", busy, 0);
        check("arst_wdata", mem_wdata, 0);
        tick();
        reset = 1'b0;
        tick();

        issue(3'b011, 6'b000000, 8'h00);
        rs_data = 8'h44;
        rt_data = 8'h44;
        tick();
        check("eq_true", eq_flag, 1);
        rt_data = 8'h45;
        tick();
        check("eq_false", eq_flag, 0);

        issue(3'b001, 6'b010000, 8'h21);
        tick();
        issue(3'b000, 6'b000000, 8'h00);
        tick();
        check("inv_err", err, 1);
        check("inv_done", done, 1);
        check("inv_acc", acc, 8'h21);

        issue(3'b111, 6'b000000, 8'h09);
        tick();
        check("ldi_we", reg_we, 1);
        check("ldi_wdata", reg_wdata, 8'h09);
        check("ldi_err_cleared", err, 0);
        start = 1'b0;
        tick();
        check("ldi_we_cleared", reg_we, 0);

        // ack while idle has no effect
        mem_ack = 1'b1;
        mem_rdata = 8'hEE;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_acc", acc, 8'h21);
        check("idle_ack_done", done, 0);
        check("idle_ack_busy", busy, 0);

`ifdef ACC_MEM_TIMEOUT_EN
        issue(3'b110, 6'b000000, 8'h40);
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("to_req_held", mem_req, 1);
            tick();
        end
        check("to_req_last", mem_req, 1);
        tick();
        check("to_req_drop", mem_req, 0);
        check("to_err", err, 1);
        check("to_done", done, 1);
        check("to_acc", acc, 8'h21);
        check("to_busy", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_exec.md
# acc_exec

Accumulator execution stage of the accumulator CPU. Sits directly downstream of the accumulator-control decoder: consumes its 3-bit `AccControl` model code plus the raw 6-bit opcode, and performs the operation: ALU update of `acc`, compare, jump/JR signalling, register-immediate load, or a handshaked data-memory load/store. Single-cycle models retire in one clock. Memory models run a small request/acknowledge state machine.

## Interface
- `W`, 8, data/accumulator/address width
- `TIMEOUT`, 15, maximum cycles to wait for `mem_ack` (used only with the configuration macro)

- `clk` in 1 — sole clock, rising edge
- `reset` in 1 — asynchronous, active-high; clears all state
- `start` in 1 — instruction valid; sampled only in IDLE
- `acc_ctl` in 3 — model code from the accumulator-control decoder
- `op` in 6 — raw opcode: `op[5:3]` class, `op[2:0]` function
- `rs_data`, `rt_data` in W — register-file read ports
- `imm` in W — zero-extended immediate
- `mem_rdata` in W — memory read data, valid with `mem_ack`
- `mem_ack` in 1 — memory acknowledge
- `acc` out W — accumulator
- `carry` out 1 — carry/borrow of last add/sub
- `eq_flag` out 1 — result of last EQ
- `busy` out 1 — high while not IDLE
- `done` out 1 — one-cycle retire pulse
- `err` out 1 — one-cycle pulse: invalid code or timeout
- `jmp` out 1 — one-cycle pulse, model4
- `jr` out 1 — one-cycle pulse, JR (target = `acc`)
- `reg_we` out 1 — one-cycle write strobe, model7
- `reg_wdata` out W — equals `imm` when `reg_we`
- `mem_req`, `mem_we` out 1 — memory request, write qualifier
- `mem_addr`, `mem_wdata` out W — latched `imm`, latched `acc`

## Operation
- States: IDLE, MEM. All outputs reset to 0. State resets to IDLE.
- IDLE with `start`=1: decode `acc_ctl`:
  - 001: `op[5:3]`=010 → `acc`+=`imm`. Otherwise, by `op[2:0]`: 000 add `rs_data`, 001 sub, 010 and, 011 or. Add/sub wrap mod 2^W and set `carry` (sub: carry=1 on borrow). Logic ops leave `carry` unchanged.
  - 010: `op[5:3]`=110 → `jr` pulse, `acc` unchanged. Otherwise `op[2:0]` 101 → `acc`<<1, 110 → `acc`>>1 logical, other → no change.
  - 011: `eq_flag`<=(`rs_data`==`rt_data`).
  - 100: `jmp` pulse.
  - 111: `reg_we` pulse, `reg_wdata`<=`imm`.
  - 101 (store) / 110 (load): latch `mem_addr`<=`imm`, `mem_wdata`<=`acc`, `mem_we`<=(code==101), `mem_req`<=1, go to MEM.
  - 000: `err` pulse, no other effect.
  - Every non-memory code, including 000, pulses `done`.
- MEM: hold `mem_req`, `mem_addr`, `mem_wdata`, and `mem_we` stable until `mem_ack`. On ack: load takes `acc`<=`mem_rdata`; clear `mem_req`/`mem_we`; pulse `done`; return to IDLE.
- `start` is ignored while `busy`; no queueing.
- Reset mid-MEM: `mem_req` drops immediately (async); the transaction is abandoned.

## Timing
- `start` in cycle T, single-cycle model: `acc`/flags/strobes updated at the T→T+1 edge; `done` high during T+1. `busy` stays 0. Back-to-back `start` every cycle is legal.
- Memory model: `mem_req` and `busy` high from T+1. `mem_ack` seen in cycle A≥T+1 → `acc` (load) and `done` valid in A+1. `busy`=0 in A+1. `start` in A+1 is accepted.
- `mem_ack` in IDLE is ignored.

## Configuration
- `ACC_MEM_TIMEOUT_EN` defined: a 4-bit-minimum counter runs in MEM. If `TIMEOUT` cycles pass without `mem_ack`, drop `mem_req`, pulse `err` and `done`, leave `acc` unchanged, return to IDLE. A counter value of 0 disables nothing; the counter restarts on each MEM entry.
- Undefined: MEM waits indefinitely; the counter logic is absent.

## Test plan
- Reset, then `acc_ctl`=001, `op`=010000, `imm`=0xFF twice → `acc`=0xFF then 0xFE, `carry`=1, `done` each cycle, `busy`=0.
- `acc`=0x05, sub with `rs_data`=0x07 → `acc`=0xFE, `carry`=1. Shift-left (010/000101) → 0xFC.
- Load `imm`=0x20, `mem_ack` delayed 3 cycles with `mem_rdata`=0x5A → `mem_req` high 3 cycles, `mem_addr`=0x20, `mem_we`=0, `acc`=0x5A and `done` in the following cycle. A `start` during MEM is ignored.
- Store with `acc`=0x33, `imm`=0x10 → `mem_we`=1, `mem_wdata`=0x33. Assert `reset` mid-MEM → all outputs 0 asynchronously.
- EQ with 0x44/0x44 → `eq_flag`=1. `acc_ctl`=000 → `err` and `done` pulse, `acc` unchanged. 111 with `imm`=0x09 → `reg_we` pulse, `reg_wdata`=0x09.
- With `ACC_MEM_TIMEOUT_EN`, `TIMEOUT`=4, no ack → `err`+`done` after 4 MEM cycles, `mem_req` drops, `acc` unchanged.
